// File: rtl/seg7_pkg.sv
// Character codes and active-low segment patterns for the
// H/E/L/O/blank seven-segment character set.
package seg7_pkg;

    localparam int CHAR_W = 3;

    localparam logic [CHAR_W-1:0] CH_H     = 3'd0;
    localparam logic [CHAR_W-1:0] CH_E     = 3'd1;
    localparam logic [CHAR_W-1:0] CH_L     = 3'd2;
    localparam logic [CHAR_W-1:0] CH_O     = 3'd3;
    localparam logic [CHAR_W-1:0] CH_BLANK = 3'd4;

    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Power-up message "HELLO" followed by blanks.
    function automatic logic [CHAR_W-1:0] reset_char(input int i);
        logic [CHAR_W-1:0] c;
        case (i)
            0:       c = CH_H;
            1:       c = CH_E;
            2:       c = CH_L;
            3:       c = CH_L;
            4:       c = CH_O;
            default: c = CH_BLANK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/seg7_char_decode.sv
// Combinational character code to active-low segment pattern.
module seg7_char_decode
    import seg7_pkg::*;
(
    input  logic [CHAR_W-1:0] code,
    output logic [6:0]        seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            CH_H:    seg = SEG_H;
            CH_E:    seg = SEG_E;
            CH_L:    seg = SEG_L;
            CH_O:    seg = SEG_O;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hello_scroller.sv
// Circular message buffer shown as a rotating window on a bank of
// seven-segment displays, with prescaled auto-scroll and single step.
module hello_scroller
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 5,
    parameter int MSG_LEN    = 8,
    parameter int TICK_DIV   = 50_000_000,
    parameter int AW         = $clog2(MSG_LEN)
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    dir,
    input  logic                    step,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [CHAR_W-1:0]       wr_data,
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic [AW-1:0]           offset,
    output logic                    adv
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0]           presc_q, presc_d;
    logic [AW-1:0]           offset_q, offset_d;
    logic                    adv_q, adv_d;
    logic [CHAR_W-1:0]       msg_q [MSG_LEN];
    logic [CHAR_W-1:0]       msg_d [MSG_LEN];
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    logic                    tick;
    logic                    wr_ok;

    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        if (run) begin
            if (presc_q == PW'(TICK_DIV - 1)) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // Steps only count while paused, so they never collide with ticks.
    always_comb begin
        adv_d    = tick || (step && !run);
        offset_d = offset_q;
        if (adv_d) begin
            if (!dir) begin
                offset_d = (offset_q == AW'(MSG_LEN - 1))
                         ? '0 : offset_q + AW'(1);
            end else begin
                offset_d = (offset_q == '0)
                         ? AW'(MSG_LEN - 1) : offset_q - AW'(1);
            end
        end
    end

    assign wr_ok = wr_en && ({1'b0, wr_addr} < (AW+1)'(MSG_LEN));

    always_comb begin
        for (int i = 0; i < MSG_LEN; i++) begin
            msg_d[i] = msg_q[i];
            if (wr_ok && (wr_addr == AW'(i)))
                msg_d[i] = wr_data;
        end
    end

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
        logic [AW:0]   sum;
        logic [AW-1:0] idx;
        always_comb begin
            sum = {1'b0, offset_q} + (AW+1)'(NUM_DIGITS - 1 - d);
            if (sum >= (AW+1)'(MSG_LEN))
                sum = sum - (AW+1)'(MSG_LEN);
        end
        assign idx = sum[AW-1:0];
        seg7_char_decode u_dec (
            .code (msg_q[idx]),
            .seg  (hex_d[7*d +: 7])
        );
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            presc_q  <= '0;
            offset_q <= '0;
            adv_q    <= 1'b0;
            hex_q    <= '1;
            for (int i = 0; i < MSG_LEN; i++)
                msg_q[i] <= reset_char(i);
        end else begin
            presc_q  <= presc_d;
            offset_q <= offset_d;
            adv_q    <= adv_d;
            hex_q    <= hex_d;
            for (int i = 0; i < MSG_LEN; i++)
                msg_q[i] <= msg_d[i];
        end
    end

    assign HEX    = hex_q;
    assign offset = offset_q;
    assign adv    = adv_q;

endmodule

// File: tb/tb_hello_scroller.sv
// Directed checks of the scrolling display with a divide-by-4 prescaler.
module tb_hello_scroller;

    localparam logic [6:0] H = 7'b0001001;
    localparam logic [6:0] E = 7'b0000110;
    localparam logic [6:0] L = 7'b1000111;
    localparam logic [6:0] O = 7'b1000000;
    localparam logic [6:0] B = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset, run, dir, step, wr_en;
    logic [2:0]  wr_addr, wr_data;
    logic [34:0] hex;
    logic [2:0]  offset;
    logic        adv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hello_scroller #(
        .NUM_DIGITS (5),
        .MSG_LEN    (8),
        .TICK_DIV   (4)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .run      (run),
        .dir      (dir),
        .step     (step),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .HEX      (hex),
        .offset   (offset),
        .adv      (adv)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [34:0] obs,
                       input logic [34:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; dir = 1'b0; step = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        cyc(2);
        chk("rst_hex", hex, {35{1'b1}});
        chk("rst_off", 35'(offset), 35'd0);
        chk("rst_adv", 35'(adv), 35'd0);

        // 1: release reset, display HELLO and hold
        reset = 1'b0;
        cyc(1);
        chk("hello", hex, {H, E, L, L, O});
        cyc(5);
        chk("hello_hold", hex, {H, E, L, L, O});
        chk("hold_off", 35'(offset), 35'd0);

        // 2: auto-scroll left
        run = 1'b1; dir = 1'b0;
        cyc(3);
        chk("pre_adv", 35'(adv), 35'd0);
        chk("pre_off", 35'(offset), 35'd0);
        cyc(1);
        chk("adv1", 35'(adv), 35'd1);
        chk("adv1_off", 35'(offset), 35'd1);
        chk("hex_lag", hex, {H, E, L, L, O});
        cyc(1);
        chk("adv1_clr", 35'(adv), 35'd0);
        chk("hex_off1", hex, {E, L, L, O, B});
        cyc(27);
        chk("adv8_off", 35'(offset), 35'd0);
        chk("adv8", 35'(adv), 35'd1);
        cyc(1);
        chk("wrap_hex", hex, {H, E, L, L, O});
        run = 1'b0;

        // 3: auto-scroll right from reset
        reset = 1'b1;
        cyc(1);
        reset = 1'b0; run = 1'b1; dir = 1'b1;
        cyc(4);
        chk("right_off", 35'(offset), 35'd7);
        chk("right_adv", 35'(adv), 35'd1);
        cyc(1);
        chk("right_hex", hex, {B, H, E, L, L});
        run = 1'b0; dir = 1'b0;

        // 4: stepping and prescaler gating
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(1);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        chk("step1_off", 35'(offset), 35'd1);
        chk("step1_adv", 35'(adv), 35'd1);
        cyc(1);
        chk("step_gap", 35'(adv), 35'd0);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        chk("step2_off", 35'(offset), 35'd2);
        chk("step2_adv", 35'(adv), 35'd1);
        run = 1'b1;
        cyc(2);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        chk("step_run_off", 35'(offset), 35'd2);
        chk("step_run_adv", 35'(adv), 35'd0);
        cyc(1);
        chk("tick_off", 35'(offset), 35'd3);
        cyc(2);
        run = 1'b0;
        cyc(3);
        chk("paused_off", 35'(offset), 35'd3);
        chk("paused_adv", 35'(adv), 35'd0);
        run = 1'b1;
        cyc(1);
        chk("resume_early", 35'(adv), 35'd0);
        cyc(1);
        chk("resume_adv", 35'(adv), 35'd1);
        chk("resume_off", 35'(offset), 35'd4);
        run = 1'b0;

        // 5: write concurrent with an advance
        reset = 1'b1;
        cyc(1);
        reset = 1'b0; run = 1'b1;
        cyc(3);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 3'd3;
        cyc(1);
        wr_en = 1'b0;
        chk("wr_adv_off", 35'(offset), 35'd1);
        run = 1'b0;
        cyc(1);
        chk("wr_dig0", 35'(hex[6:0]), 35'(O));
        chk("wr_hex", hex, {E, L, L, O, O});

        // 6: reset discards written data mid-scroll
        step = 1'b1;
        cyc(2);
        step = 1'b0;
        chk("pre_rst_off", 35'(offset), 35'd3);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 3'd2;
        cyc(1);
        wr_en = 1'b0;
        cyc(1);
        chk("off3_hex", hex, {L, O, O, B, B});
        reset = 1'b1;
        cyc(1);
        chk("mid_rst_off", 35'(offset), 35'd0);
        chk("mid_rst_hex", hex, {35{1'b1}});
        reset = 1'b0;
        cyc(1);
        chk("post_rst_hex", hex, {H, E, L, L, O});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hello_scroller.md
# hello_scroller

Parametrised scrolling character display for the DE2 seven-segment bank, extending the 3-bit H/E/L/O/blank character scheme. A circular message buffer of `MSG_LEN` 3-bit character codes is shown as a `NUM_DIGITS`-wide window. The window rotates left or right at a prescaled rate, or advances by single steps while paused. It sits between the switch/key inputs and the `HEX` outputs at the top of a lab design.

## Interface

Parameters:
- `NUM_DIGITS`, 5: displays driven (1..8).
- `MSG_LEN`, 8: message buffer entries (≥ `NUM_DIGITS`, ≥ 2).
- `TICK_DIV`, 50_000_000: clock cycles per scroll advance (≥ 1).
- `AW`, `$clog2(MSG_LEN)`: derived address width; not overridden.

Ports:
- `CLOCK_50` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `run` in 1: 1 = auto-scroll enabled.
- `dir` in 1: 0 = text moves left (offset +1); 1 = text moves right (offset −1).
- `step` in 1: one-cycle pulse, advances one position; honoured only when `run`=0.
- `wr_en` in 1: buffer write strobe.
- `wr_addr` in `AW`: buffer index; writes with `wr_addr` ≥ `MSG_LEN` are ignored.
- `wr_data` in 3: character code.
- `HEX` out `7*NUM_DIGITS`: registered, active-low segments; digit d occupies `[7d+6:7d]`, bit i = segment i (a=0 … g=6); digit 0 is the rightmost display.
- `offset` out `AW`: current window start index.
- `adv` out 1: one-cycle pulse on each offset change.

## Operation

- Character codes: 0 = H, 1 = E, 2 = L, 3 = O, 4..7 = blank.
- Digit d shows `buf[(offset + NUM_DIGITS−1−d) mod MSG_LEN]`. The leftmost digit therefore shows `buf[offset]`.
- Reset state:
  - Buffer: indices 0..4 = H, E, L, L, O; all remaining entries = blank. Any entries beyond `MSG_LEN` are simply dropped.
  - `offset` = 0, prescaler = 0, `adv` = 0.
  - `HEX` = all ones (blank).
  - User-written buffer contents are lost on any reset, including a reset asserted mid-scroll.
- Prescaler:
  - Counts 0..`TICK_DIV`−1 only while `run`=1 and holds its value while `run`=0.
  - Reaching `TICK_DIV`−1 wraps it to 0 and issues an advance.
  - With `TICK_DIV`=1, an advance occurs every cycle while `run`=1.
- Advance:
  - `dir`=0: `offset` ← (`offset`+1) mod `MSG_LEN`, wrapping `MSG_LEN`−1 → 0.
  - `dir`=1: `offset` ← (`offset`−1) mod `MSG_LEN`, wrapping 0 → `MSG_LEN`−1.
  - `dir` is sampled at the advance edge only.
- `step` while `run`=1 is ignored. Step and timer advances are therefore mutually exclusive.
- Writes and advances in the same cycle are both performed.
- `HEX` is decoded from the post-update `offset` and buffer.

## Timing

- All outputs are registered.
- Edge k performing an advance:
  - `offset` and `adv`=1 are valid after edge k.
  - `adv` returns to 0 after edge k+1 unless another advance occurs.
- `HEX` lags buffer and `offset` by one edge: it is decoded at edge k+1 from the state present after edge k.
- A write at edge k is visible on `HEX` after edge k+1.
- First non-blank `HEX` appears one edge after `reset` deasserts.
- Segment patterns (bit6..bit0, i.e. g..a):
  - H = `0001001`
  - E = `0000110`
  - L = `1000111`
  - O = `1000000`
  - blank = `1111111`

## Structure

- Package `seg7_pkg` holds:
  - `CHAR_W`=3.
  - Code constants `CH_H`, `CH_E`, `CH_L`, `CH_O`, `CH_BLANK`.
  - Segment constants `SEG_H`, `SEG_E`, `SEG_L`, `SEG_O`, `SEG_BLANK`.
- Sub-module `seg7_char_decode`: combinational 3-bit code → 7-bit active-low pattern, instantiated `NUM_DIGITS` times in a generate loop.
- Top level holds the buffer (flop array), prescaler, offset register and output register.

## Test plan

All scenarios use `NUM_DIGITS`=5, `MSG_LEN`=8, `TICK_DIV`=4.

1. Release `reset`, `run`=0 → one edge later, `HEX`[34:0] reads H E L L O (digit 4 → digit 0), `offset`=0, `adv`=0; holds indefinitely.
2. `run`=1, `dir`=0 → `adv` pulses every 4 cycles. After the first advance, `offset`=1 and `HEX` shows E L L O blank one edge later. After 8 advances, `offset`=0 again.
3. From reset, `run`=1, `dir`=1 → first advance gives `offset`=7, display blank H E L L.
4. Step and prescaler gating:
   - `run`=0, `step` pulsed twice → `offset`=2, `adv` pulses twice.
   - `step` with `run`=1 mid-count → no extra advance.
   - Dropping `run` at prescaler=2 then raising it again → the next advance arrives 2 cycles later.
5. Write `wr_addr`=5, `wr_data`=3 in the same cycle as an advance from `offset`=0 → `offset`=1, and one edge later digit 0 shows O (`1000000`).
6. Assert `reset` for one cycle at `offset`=3 after writing index 0 = L → `offset`=0, `HEX` blank. One edge after deassert, the display shows H E L L O (the written L is discarded).
